arith_seq_unit: RTL
===================

# arith_seq_unit

Parametrised sequential arithmetic unit, next generation of the package-level add/sub operation list and the a/b/m port structure. It accepts one operand pair plus opcode over a valid/ready handshake and computes ADD, SUB or MUL. MUL uses an iterative shift-add multiplier. The unit returns a double-width result over a second valid/ready handshake. It sits between an operand producer and a result consumer and holds each result until the consumer accepts it.

## Interface
- WIDTH, 5, operand width in bits (≥2); result width is 2*WIDTH
- OP_W, 2, opcode width; encoding 0=ADD, 1=SUB, 2=MUL, 3=reserved
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand pair and opcode valid
- in_ready  out  1  unit can accept operands
- in_op  in  OP_W  opcode
- in_a  in  WIDTH  operand a, unsigned
- in_b  in  WIDTH  operand b, unsigned
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_m  out  2*WIDTH  result
- out_err  out  1  result came from reserved opcode

## Operation
- States:
  - IDLE: in_ready=1.
  - BUSY: MUL iterating; in_ready=0.
  - DONE: out_valid=1; in_ready=0.
- IDLE: on in_valid && in_ready, capture op, a and b.
  - ADD, SUB, reserved: go to DONE.
  - MUL: clear accumulator, load iteration counter to WIDTH, go to BUSY.
- Arithmetic, all modulo 2^(2*WIDTH), with a and b zero-extended:
  - ADD: m = a + b.
  - SUB: m = a − b (two's complement wrap when b > a).
  - MUL: m = a * b, exact.
  - Reserved: m = 0, out_err = 1. For all other ops out_err = 0.
- BUSY, each cycle:
  - If b register LSB is 1, accumulator += shifted a.
  - Shift a left by 1 and b right by 1; decrement counter.
  - When the counter reaches 1 on the current cycle, go to DONE next cycle, with the accumulator holding the final product.
- DONE: out_m and out_err are stable and unchanged until the handshake. On out_valid && out_ready, go to IDLE.
- in_valid is ignored in BUSY and DONE; the producer must hold its data until in_ready.
- out_ready is ignored while out_valid=0.

## Timing
- Reset (rst_n=0 at a rising edge), taking effect at that edge:
  - State goes to IDLE: in_ready=1, out_valid=0, out_m=0, out_err=0; counter and accumulator cleared.
  - Reset mid-BUSY or mid-DONE aborts the operation; no result is emitted.
- Accept edge = cycle 0.
  - ADD/SUB/reserved: out_valid=1 from cycle 1.
  - MUL: out_valid=1 from cycle WIDTH+1.
- Result handshake completes at the edge where out_valid && out_ready. On the next cycle out_valid=0 and in_ready=1.
  - out_m keeps its last value in IDLE; do not clear it.
- Throughput:
  - ADD/SUB: 1 op per 2 cycles minimum, with out_ready held at 1.
  - MUL: 1 op per WIDTH+2 cycles minimum.
- A new accept is never in the same cycle as a result handshake, because in_ready=0 in DONE.
- in_ready and out_valid are registered (state-decoded); they have no combinational path from in_valid or out_ready.

## Test plan
- WIDTH=5, ADD a=31, b=31, out_ready=1:
  - out_valid rises 1 cycle after accept, out_m=62, out_err=0.
  - in_ready returns 1 cycle after the handshake.
- SUB a=3, b=5:
  - out_m=1022 (2^10−2).
  - Also SUB a=20, b=7 → out_m=13.
- MUL a=31, b=31:
  - out_valid exactly 6 cycles after accept, out_m=961.
  - MUL a=0, b=17 → 0, same latency.
  - MUL a=1, b=1 → 1.
- Backpressure: MUL a=12, b=11 with out_ready=0 for 10 cycles after out_valid.
  - out_m=132 held stable and out_valid held high throughout.
  - in_valid pulses with other operands meanwhile are ignored.
  - out_ready=1 then gives a single handshake.
- Reserved op=3, a=9, b=9: out_m=0, out_err=1. A following ADD 1+2 gives out_m=3, out_err=0.
- rst_n=0 for one cycle during MUL BUSY cycle 3:
  - Next cycle: in_ready=1, out_valid=0, out_m=0.
  - No stale result later.
  - A new MUL 7*9 yields 63 with normal latency.

Source files
------------

// File: rtl/arith_seq_unit.sv
// Sequential ADD/SUB/MUL unit with double-width result (MUL is iterative shift-add).
// Latency: ADD/SUB/reserved -> out_valid one cycle after accept; MUL -> WIDTH+1 cycles after accept.
// Backpressure: result is held stable in DONE until out_ready; no new operands accepted until then.
//
// Ports:
//   clk, rst_n               single rising-edge clock, synchronous active-low reset
//   in_valid/in_ready        operand handshake (in_op, in_a, in_b captured on accept)
//   out_valid/out_ready      result handshake (out_m, out_err)
//   out_m                    2*WIDTH-bit result, modulo 2^(2*WIDTH)
//   out_err                  set when the result came from the reserved opcode
module arith_seq_unit #(
    parameter int WIDTH = 5,
    parameter int OP_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_W-1:0]      in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_m,
    output logic                 out_err
);

    localparam int RW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
    localparam logic [OP_W-1:0] OP_MUL = OP_W'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [RW-1:0]    a_sh;      // multiplicand, shifted left each iteration
    logic [WIDTH-1:0] b_sh;      // multiplier, shifted right each iteration
    logic [RW-1:0]    acc;       // partial product
    logic [CNT_W-1:0] cnt;       // remaining iterations
    logic [RW-1:0]    m_r;
    logic             err_r;

    logic [RW-1:0]    a_ext;
    logic [RW-1:0]    b_ext;
    logic [RW-1:0]    acc_step;
    logic             accept;
    logic             last_iter;

    assign a_ext     = {{WIDTH{1'b0}}, in_a};
    assign b_ext     = {{WIDTH{1'b0}}, in_b};
    assign acc_step  = b_sh[0] ? (acc + a_sh) : acc;
    assign accept    = in_valid && (state == S_IDLE);
    assign last_iter = (state == S_BUSY) && (cnt == CNT_W'(1));

    // Handshake outputs decode straight from the state register, so neither
    // ready nor valid has a combinational path from the opposite handshake.
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign out_m     = m_r;
    assign out_err   = err_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_nxt = (in_op == OP_MUL) ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            cnt   <= '0;
            m_r   <= '0;
            err_r <= 1'b0;
        end else if (accept) begin
            a_sh <= a_ext;
            b_sh <= in_b;
            acc  <= '0;
            cnt  <= CNT_W'(WIDTH);
            case (in_op)
                OP_ADD: begin
                    m_r   <= a_ext + b_ext;
                    err_r <= 1'b0;
                end
                OP_SUB: begin
                    m_r   <= a_ext - b_ext;
                    err_r <= 1'b0;
                end
                OP_MUL: begin
                    // out_m keeps its previous value until the product is ready.
                    err_r <= 1'b0;
                end
                default: begin
                    m_r   <= '0;
                    err_r <= 1'b1;
                end
            endcase
        end else if (state == S_BUSY) begin
            acc  <= acc_step;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt - CNT_W'(1);
            // The final partial sum goes straight to the output register so
            // the product is visible in the first DONE cycle.
            if (last_iter) begin
                m_r <= acc_step;
            end
        end
    end

endmodule
